// File: rtl/mul_pkg.sv
// Shared types for the multiplier operand issuer: FSM state encoding and
// the operand pair that travels through the operand FIFO.
package mul_pkg;

  // Operand width the packed pair is laid out for; the issuer's NUM_BITS
  // defaults to this value.
  localparam int MUL_NUM_BITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } issuer_state_t;

  typedef struct packed {
    logic                    sign;
    logic [MUL_NUM_BITS-1:0] a;
    logic [MUL_NUM_BITS-1:0] b;
  } operand_pair_t;

  localparam int PAIR_W = $bits(operand_pair_t);

endpackage

// File: rtl/operand_fifo.sv
// Synchronous first-word-fall-through FIFO holding operand pairs until the
// issuer is ready to start the next multiplication. Pointers wrap modulo
// DEPTH; a separate occupancy counter distinguishes full from empty.
module operand_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok;
  logic             pop_ok;

  // Occupancy is registered state only, so full/empty carry no path from
  // the push/pop requests of the current cycle.
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage array; written on accepted pushes, contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave the
  // count unchanged while both pointers advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mul_operand_issuer.sv
// Front-end for the sequential radix-4 shift-add multiplier. Buffers operand
// pairs, starts one multiplication at a time with a single-cycle load pulse,
// waits a fixed latency (the multiplier has no done flag) and returns the
// product over a valid/ready stream.
module mul_operand_issuer
  import mul_pkg::*;
#(
  parameter int NUM_BITS    = MUL_NUM_BITS,
  parameter int DEPTH       = 4,
  parameter int MUL_LATENCY = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_signed,
  input  logic [NUM_BITS-1:0] in_a,
  input  logic [NUM_BITS-1:0] in_b,
  output logic                mul_load,
  output logic                mul_sign,
  output logic [NUM_BITS-1:0] mul_a,
  output logic [NUM_BITS-1:0] mul_b,
  input  logic [NUM_BITS-1:0] mul_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_result,
  output logic                out_signed
);

  localparam int CNT_W = $clog2(MUL_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);

  issuer_state_t   state_q;
  logic [CNT_W-1:0] cnt_q;
  operand_pair_t   push_pair;
  operand_pair_t   head_pair;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop_d;

  // Pack the incoming pair in the shared struct layout.
  always_comb begin
    push_pair      = '0;
    push_pair.sign = in_signed;
    push_pair.a    = in_a;
    push_pair.b    = in_b;
  end

  // A new operation starts only from IDLE with no product awaiting hand-off;
  // this is the only place the FIFO is popped.
  assign pop_d    = (state_q == IDLE) && !fifo_empty && !out_valid;
  assign in_ready = !fifo_full;

  operand_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAIR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (push_pair),
    .pop   (pop_d),
    .rdata (head_pair),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue FSM: owns the multiplier's timing, holds operands stable for the
  // whole operation and registers every output it drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mul_load   <= 1'b0;
      mul_sign   <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_signed <= 1'b0;
    end else begin
      mul_load <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop_d) begin
            state_q  <= ISSUE;
            mul_load <= 1'b1;
            mul_sign <= head_pair.sign;
            mul_a    <= head_pair.a;
            mul_b    <= head_pair.b;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            // The multiplier exposes one result bus per mode; the caller
            // wires the one matching mul_sign, so a single capture suffices.
            out_result <= mul_result;
            out_signed <= mul_sign;
            out_valid  <= 1'b1;
            state_q    <= HOLD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_operand_issuer.sv
// Directed bench for mul_operand_issuer with a behavioural stand-in for the
// fixed-latency multiplier that drives junk until its latency has elapsed.
module tb_mul_operand_issuer;

  localparam int NB    = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_signed = 1'b0;
  logic [NB-1:0] in_a = '0;
  logic [NB-1:0] in_b = '0;
  logic          mul_load;
  logic          mul_sign;
  logic [NB-1:0] mul_a;
  logic [NB-1:0] mul_b;
  logic [NB-1:0] mul_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NB-1:0] out_result;
  logic          out_signed;

  int total = 0;
  int bad = 0;

  mul_operand_issuer #(
    .NUM_BITS    (NB),
    .DEPTH       (DEPTH),
    .MUL_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_load   (mul_load),
    .mul_sign   (mul_sign),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_signed (out_signed)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: result is valid LAT cycles after the load edge.
  logic [NB-1:0] mprod = '0;
  int            mcnt = 0;
  always @(posedge clk) begin
    if (mul_load) begin
      mprod <= mul_a * mul_b;
      mcnt  <= 1;
    end else if (mcnt < 100000) begin
      mcnt <= mcnt + 1;
    end
  end
  assign mul_result = (mcnt >= LAT) ? mprod : 32'hDEAD_BEEF;

  // Monitors: load pulse count / longest run, sign stability, cycle count.
  int load_cnt = 0;
  int run = 0;
  int max_run = 0;
  int cycle = 0;
  int sdrop = 0;
  logic sign_watch = 1'b0;
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (mul_load) begin
      load_cnt <= load_cnt + 1;
      run      <= run + 1;
      if (run + 1 > max_run) max_run <= run + 1;
    end else begin
      run <= 0;
    end
    if (sign_watch && !mul_sign) sdrop <= sdrop + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("out_valid seen", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic drive(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic s);
    in_a = a;
    in_b = b;
    in_signed = s;
    in_valid = 1'b1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, " in_ready"},   {63'd0, in_ready},   64'd1);
    chk({pfx, " mul_load"},   {63'd0, mul_load},   64'd0);
    chk({pfx, " mul_sign"},   {63'd0, mul_sign},   64'd0);
    chk({pfx, " mul_a"},      {32'd0, mul_a},      64'd0);
    chk({pfx, " mul_b"},      {32'd0, mul_b},      64'd0);
    chk({pfx, " out_valid"},  {63'd0, out_valid},  64'd0);
    chk({pfx, " out_result"}, {32'd0, out_result}, 64'd0);
    chk({pfx, " out_signed"}, {63'd0, out_signed}, 64'd0);
  endtask

  logic [NB-1:0] exp_r [6];
  logic          exp_s [6];
  int            t_out [6];

  initial begin
    int cyc;
    int lc;
    int n;
    int seen;

    // Reset values while rst_n is held low.
    #3;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Unsigned single op: 3*5, single load pulse, MUL_LATENCY+3 latency.
    out_ready = 1'b0;
    drive(32'd3, 32'd5, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_out(cyc);
    chk("t1 latency", cyc + 1, LAT + 3);
    chk("t1 result", {32'd0, out_result}, 64'd15);
    chk("t1 signed", {63'd0, out_signed}, 64'd0);
    chk("t1 loads", load_cnt, 1);
    chk("t1 load width", max_run, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1 handshake", {63'd0, out_valid}, 64'd0);

    // Signed op: -7 * 6 = -42.
    drive(32'hFFFF_FFF9, 32'd6, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    sign_watch = 1'b1;
    wait_out(cyc);
    sign_watch = 1'b0;
    chk("t2 latency", cyc + 2, LAT + 3);
    chk("t2 sign drops", sdrop, 0);
    chk("t2 mul_sign", {63'd0, mul_sign}, 64'd1);
    chk("t2 mul_a", {32'd0, mul_a}, 64'hFFFF_FFF9);
    chk("t2 mul_b", {32'd0, mul_b}, 64'd6);
    chk("t2 result", {32'd0, out_result}, 64'hFFFF_FFD6);
    chk("t2 signed", {63'd0, out_signed}, 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Fill FIFO behind a pending product, with output backpressure.
    exp_r[0] = 32'd6;        exp_s[0] = 1'b0;
    exp_r[1] = 32'd20;       exp_s[1] = 1'b0;
    exp_r[2] = 32'd56;       exp_s[2] = 1'b0;
    exp_r[3] = 32'hFFFF_FFEE; exp_s[3] = 1'b1;
    exp_r[4] = 32'd132;      exp_s[4] = 1'b0;
    exp_r[5] = 32'd182;      exp_s[5] = 1'b0;
    drive(32'd2, 32'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_out(cyc);
    lc = load_cnt;
    chk("t3 ready 1", {63'd0, in_ready}, 64'd1);
    drive(32'd4, 32'd5, 1'b0);          tick();
    chk("t3 ready 2", {63'd0, in_ready}, 64'd1);
    drive(32'd7, 32'd8, 1'b0);          tick();
    chk("t3 ready 3", {63'd0, in_ready}, 64'd1);
    drive(32'hFFFF_FFFE, 32'd9, 1'b1);  tick();
    chk("t3 ready 4", {63'd0, in_ready}, 64'd1);
    drive(32'd11, 32'd12, 1'b0);        tick();
    chk("t3 full", {63'd0, in_ready}, 64'd0);
    drive(32'd13, 32'd14, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("t3 stalled", {63'd0, in_ready}, 64'd0);
    chk("bp valid", {63'd0, out_valid}, 64'd1);
    chk("bp result", {32'd0, out_result}, 64'd6);
    chk("bp loads", load_cnt - lc, 0);
    chk("bp mul_a", {32'd0, mul_a}, 64'd2);
    chk("bp mul_b", {32'd0, mul_b}, 64'd3);
    out_ready = 1'b1;
    fork
      begin
        n = 0;
        while (!in_ready && n < 400) begin
          tick();
          n++;
        end
        chk("t3 stalled push accepted", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++) begin
          wait_out(cyc);
          t_out[k] = cycle;
          chk($sformatf("t3 result %0d", k), {32'd0, out_result}, {32'd0, exp_r[k]});
          chk($sformatf("t3 signed %0d", k), {63'd0, out_signed}, {63'd0, exp_s[k]});
          tick();
        end
      end
    join
    chk("t3 throughput", t_out[3] - t_out[2], LAT + 3);
    out_ready = 1'b0;

    // Simultaneous push/pop with occupancy at DEPTH-1; pointers have wrapped.
    drive(32'd21, 32'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_out(cyc);
    drive(32'd3, 32'd3, 1'b0);                 tick();
    drive(32'd5, 32'd6, 1'b0);                 tick();
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); tick();
    in_valid = 1'b0;
    chk("t4 occ3 ready", {63'd0, in_ready}, 64'd1);
    chk("t4 q0 result", {32'd0, out_result}, 64'd42);
    out_ready = 1'b1;
    tick();
    chk("t4 handshake", {63'd0, out_valid}, 64'd0);
    drive(32'd10, 32'd10, 1'b0);
    tick();
    chk("t4 pushpop ready", {63'd0, in_ready}, 64'd1);
    chk("t4 pushpop load", {63'd0, mul_load}, 64'd1);
    chk("t4 pushpop mul_a", {32'd0, mul_a}, 64'd3);
    drive(32'd8, 32'd8, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t4 now full", {63'd0, in_ready}, 64'd0);
    exp_r[0] = 32'd9;   exp_s[0] = 1'b0;
    exp_r[1] = 32'd30;  exp_s[1] = 1'b0;
    exp_r[2] = 32'd1;   exp_s[2] = 1'b1;
    exp_r[3] = 32'd100; exp_s[3] = 1'b0;
    exp_r[4] = 32'd64;  exp_s[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_out(cyc);
      chk($sformatf("t4 result %0d", k), {32'd0, out_result}, {32'd0, exp_r[k]});
      chk($sformatf("t4 signed %0d", k), {63'd0, out_signed}, {63'd0, exp_s[k]});
      tick();
    end
    out_ready = 1'b0;

    // Asynchronous reset at WAIT count 10 with a second pair queued.
    drive(32'hFFFF_FF9C, 32'd3, 1'b1);
    tick();
    drive(32'd5, 32'd5, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("t6 pre sign", {63'd0, mul_sign}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6 async");
    lc = load_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("t6 no out_valid", seen, 0);
    chk("t6 fifo empty", load_cnt - lc, 0);
    drive(32'd2, 32'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_out(cyc);
    chk("t6 latency", cyc + 1, LAT + 3);
    chk("t6 result", {32'd0, out_result}, 64'd4);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
